// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: store-type encodings (shared with data memory)
// and the layout of one buffered store.
package store_buffer_pkg;

    localparam logic [4:0] SAVE_SB = 5'd1;
    localparam logic [4:0] SAVE_SH = 5'd2;
    localparam logic [4:0] SAVE_SW = 5'd3;

    // Clears the byte-offset bits, so stores and loads are matched by 32-bit word.
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  ctrl;
        logic [31:0] pc;
    } sb_entry_t;

    function automatic logic is_store_ctrl(input logic [4:0] ctrl);
        return (ctrl == SAVE_SB) || (ctrl == SAVE_SH) || (ctrl == SAVE_SW);
    endfunction

    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & WORD_MASK) == 32'd0;
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular entry array with read/write pointers, occupancy count and per-slot valid bits.
// Pushes are ignored when full and pops are ignored when empty.
module store_buffer_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  sb_entry_t             i_entry,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [PTR_W:0]        o_count,
    output sb_entry_t             o_head,
    output sb_entry_t [DEPTH-1:0] o_entries,
    output logic [DEPTH-1:0]      o_valid
);

    sb_entry_t [DEPTH-1:0] r_mem;
    logic [DEPTH-1:0]      r_valid;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // A gated push never targets the slot being popped: an empty buffer cannot pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem    <= '0;
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr]   <= i_entry;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_entries = r_mem;
    assign o_valid   = r_valid;

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM-stage store path and the data-memory write port.
// Drains one store per cycle when no load needs the port, and flags loads that hit a buffered word.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [4:0]       st_ctrl,
    input  logic [31:0]      st_pc,
    output logic             st_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             ld_conflict,
    output logic             dm_wEn,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_dIn,
    output logic [4:0]       dm_saveCtrl,
    output logic [31:0]      dm_pc,
    output logic [PTR_W:0]   count
);

    sb_entry_t             w_new_entry;
    sb_entry_t             w_head;
    sb_entry_t [DEPTH-1:0] w_entries;
    logic [DEPTH-1:0]      w_valid;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_drain;
    logic                  w_hit;

    assign w_new_entry = '{addr: st_addr, data: st_data, ctrl: st_ctrl, pc: st_pc};
    assign st_ready    = !w_full;
    assign w_push      = st_valid && st_ready && is_store_ctrl(st_ctrl);

    store_buffer_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_entry   (w_new_entry),
        .i_pop     (w_drain),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (count),
        .o_head    (w_head),
        .o_entries (w_entries),
        .o_valid   (w_valid)
    );

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && same_word(w_entries[i].addr, ld_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign ld_conflict = ld_valid && w_hit;

    // A conflicting load is stalled waiting on this drain, so it must not block it.
    assign w_drain = !w_empty && (!ld_valid || ld_conflict);

    always_comb begin
        dm_wEn      = 1'b0;
        dm_addr     = '0;
        dm_dIn      = '0;
        dm_saveCtrl = '0;
        dm_pc       = '0;
        if (w_drain) begin
            dm_wEn      = 1'b1;
            dm_addr     = w_head.addr;
            dm_dIn      = w_head.data;
            dm_saveCtrl = w_head.ctrl;
            dm_pc       = w_head.pc;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model predicts occupancy,
// ready, conflict and drain; a separate monitor checks each drained write against push order.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [4:0]       st_ctrl;
    logic [31:0]      st_pc;
    logic             st_ready;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             ld_conflict;
    logic             dm_wEn;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_dIn;
    logic [4:0]       dm_saveCtrl;
    logic [31:0]      dm_pc;
    logic [PTR_W:0]   count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [4:0]  ctrl;
    } st_t;

    st_t modelQ[$];
    st_t expQ[$];
    int  checks = 0;
    int  errors = 0;

    logic [31:0] fillAddr[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [4:0]  fillCtrl[4] = '{SAVE_SB, SAVE_SH, SAVE_SW, SAVE_SW};

    store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ctrl     (st_ctrl),
        .st_pc       (st_pc),
        .st_ready    (st_ready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .dm_wEn      (dm_wEn),
        .dm_addr     (dm_addr),
        .dm_dIn      (dm_dIn),
        .dm_saveCtrl (dm_saveCtrl),
        .dm_pc       (dm_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic bit modelConflict(input logic [31:0] la);
        foreach (modelQ[i]) begin
            if (modelQ[i].addr[31:2] == la[31:2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Called just after a falling edge: drives one cycle, checks the combinational
    // outputs against the model, then advances the model across the rising edge.
    task automatic applyStimulus(input logic sv, input logic [31:0] a, input logic [31:0] d,
                                 input logic [4:0] c, input logic [31:0] p,
                                 input logic lv, input logic [31:0] la);
        st_t e;
        bit  expReady, expConf, expDrain, expPush;
        st_valid = sv;
        st_addr  = a;
        st_data  = d;
        st_ctrl  = c;
        st_pc    = p;
        ld_valid = lv;
        ld_addr  = la;
        #1;
        expReady = (modelQ.size() != DEPTH);
        expConf  = lv && modelConflict(la);
        expDrain = (modelQ.size() != 0) && (!lv || expConf);
        expPush  = sv && expReady && (c >= 5'd1) && (c <= 5'd3);
        checkOutput("count", 32'(count), 32'(modelQ.size()));
        checkOutput("st_ready", 32'(st_ready), 32'(expReady));
        checkOutput("ld_conflict", 32'(ld_conflict), 32'(expConf));
        checkOutput("dm_wEn", 32'(dm_wEn), 32'(expDrain));
        e.addr = a;
        e.data = d;
        e.pc   = p;
        e.ctrl = c;
        if (expPush) expQ.push_back(e);
        @(posedge clk);
        if (expDrain) void'(modelQ.pop_front());
        if (expPush) modelQ.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic lv, input logic [31:0] la);
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, lv, la);
    endtask

    task automatic pushStore(input logic [31:0] a, input logic [4:0] c,
                             input logic lv, input logic [31:0] la);
        applyStimulus(1'b1, a, $urandom, c, $urandom, lv, la);
    endtask

    // Asserted mid-cycle with a matching load present: everything must clear at once.
    task automatic applyReset(input logic [31:0] la);
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = la;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_dm_wEn", 32'(dm_wEn), 32'h0);
        checkOutput("rst_ld_conflict", 32'(ld_conflict), 32'h0);
        checkOutput("rst_st_ready", 32'(st_ready), 32'h1);
        modelQ.delete();
        expQ.delete();
        @(negedge clk);
        reset    = 1'b1;
        ld_valid = 1'b0;
    endtask

    // Monitor: every drain write must be the oldest outstanding store.
    initial begin
        st_t h;
        forever begin
            @(negedge clk);
            #2;
            if (dm_wEn) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_drain actual=addr 0x%08h required=no write", dm_addr);
                end else begin
                    h = expQ.pop_front();
                    checkOutput("dm_addr", dm_addr, h.addr);
                    checkOutput("dm_dIn", dm_dIn, h.data);
                    checkOutput("dm_saveCtrl", 32'(dm_saveCtrl), 32'(h.ctrl));
                    checkOutput("dm_pc", dm_pc, h.pc);
                end
            end else begin
                checkOutput("dm_idle_zero", dm_addr | dm_dIn | dm_pc | 32'(dm_saveCtrl), 32'h0);
            end
        end
    end

    initial begin
        reset    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_ctrl  = '0;
        st_pc    = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        #1;
        checkOutput("init_count", 32'(count), 32'h0);
        checkOutput("init_st_ready", 32'(st_ready), 32'h1);
        checkOutput("init_dm_wEn", 32'(dm_wEn), 32'h0);
        checkOutput("init_ld_conflict", 32'(ld_conflict), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] single sw then drain");
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, SAVE_SW, 32'h400, 1'b0, 32'h0);
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);

        $display("[TB] fill behind a non-conflicting load, reject when full, then drain");
        for (int i = 0; i < 4; i++) pushStore(fillAddr[i], fillCtrl[i], 1'b1, 32'h200);
        pushStore(32'h50, SAVE_SW, 1'b1, 32'h200);
        repeat (5) idle(1'b0, 32'h0);

        $display("[TB] conflicting load lets the drain through");
        pushStore(32'h24, SAVE_SW, 1'b0, 32'h0);
        idle(1'b1, 32'h26);
        idle(1'b1, 32'h26);

        $display("[TB] non-conflicting load holds the drain");
        pushStore(32'h24, SAVE_SW, 1'b1, 32'h30);
        idle(1'b1, 32'h30);
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);

        $display("[TB] full buffer streaming push+drain with pointer wrap");
        for (int i = 0; i < 4; i++) pushStore(32'h100 + 32'(4 * i), SAVE_SW, 1'b1, 32'h200);
        for (int i = 0; i < 10; i++) pushStore(32'h140 + 32'(4 * i), SAVE_SH, 1'b0, 32'h0);
        repeat (5) idle(1'b0, 32'h0);

        $display("[TB] reset with pending stores");
        for (int i = 0; i < 3; i++) pushStore(32'h300 + 32'(4 * i), SAVE_SB, 1'b1, 32'h200);
        applyReset(32'h300);
        repeat (3) idle(1'b0, 32'h0);

        $display("[TB] randomized traffic");
        repeat (400) begin
            applyStimulus(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                          5'($urandom_range(0, 4)), $urandom,
                          ($urandom_range(0, 9) < 4), 32'($urandom_range(0, 63)));
        end
        repeat (8) idle(1'b0, 32'h0);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
